// File: rtl/audio_pwm_player_pkg.sv
// Shared constants for the audio player: PicoBlaze port map, status bit layout, PWM midscale.
// Status byte is assembled by the controller from the player's flag outputs.
package audio_pwm_player_pkg;

    localparam logic [7:0] SAMPLE_PORT       = 8'h06;
    localparam logic [7:0] AUDIO_STATUS_PORT = 8'h07;

    localparam int STAT_EMPTY_BIT    = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_UNDERRUN_BIT = 2;
    localparam int STAT_OVERFLOW_BIT = 3;

    localparam logic [7:0] PWM_MIDSCALE = 8'h80;

    function automatic logic [7:0] pack_status(input logic empty, input logic full,
                                               input logic underrun, input logic overflow);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_EMPTY_BIT]    = empty;
        s[STAT_FULL_BIT]     = full;
        s[STAT_UNDERRUN_BIT] = underrun;
        s[STAT_OVERFLOW_BIT] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/audio_pwm_player_if.sv
// Firmware-facing bus of the audio player: sample write strobe, control levels and FIFO status.
// master = PicoBlaze/controller side, slave = player.
interface audio_pwm_player_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      sample_in;
    logic            write_sample;
    logic            enable;
    logic            clear_flags;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ADDR_W:0] fifo_count;
    logic            underrun;
    logic            overflow;
    logic            pwm_out;

    modport master (
        output sample_in, write_sample, enable, clear_flags,
        input  fifo_full, fifo_empty, fifo_count, underrun, overflow, pwm_out
    );

    modport slave (
        input  sample_in, write_sample, enable, clear_flags,
        output fifo_full, fifo_empty, fifo_count, underrun, overflow, pwm_out
    );
endinterface

// File: rtl/audio_pwm_player_sample_fifo.sv
// Synchronous sample FIFO with explicit occupancy counter; status valid 1 cycle after push/pop.
// A pop in the same cycle frees a slot, so push-while-full is accepted when popping.
module audio_pwm_player_sample_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            pop_i,
    output logic [7:0]      data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [ADDR_W:0] count_o,
    output logic            ovf_attempt_o
);
    localparam int CNT_W = ADDR_W + 1;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok        = pop_i && !empty_o;
        push_ok       = push_i && (!full_o || pop_ok);
        ovf_attempt_o = push_i && !push_ok;
        wr_ptr_d      = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d       = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a reset discards contents through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/audio_pwm_player.sv
// Audio sample player: FIFO-buffered samples popped at SAMPLE_HZ drive an 8-bit free-running PWM.
// Sample reaches pwm_out 2 edges after its tick; no backpressure, firmware paces on fifo status.
module audio_pwm_player
    import audio_pwm_player_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int SAMPLE_HZ  = 8000,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    audio_pwm_player_if.slave   bus
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;
    logic [7:0]       cur_sample_q, cur_sample_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic             pwm_out_q, pwm_out_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;

    logic [7:0]       fifo_data;
    logic             fifo_full, fifo_empty, ovf_attempt;
    logic [ADDR_W:0]  fifo_count;

    audio_pwm_player_sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_sample_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (bus.write_sample),
        .data_i        (bus.sample_in),
        .pop_i         (tick),
        .data_o        (fifo_data),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .count_o       (fifo_count),
        .ovf_attempt_o (ovf_attempt)
    );

    assign tick = bus.enable && (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        div_cnt_d = '0;
        if (bus.enable && !tick) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        cur_sample_d = cur_sample_q;
        if (!bus.enable) begin
            cur_sample_d = PWM_MIDSCALE;
        end else if (tick) begin
            cur_sample_d = fifo_empty ? PWM_MIDSCALE : fifo_data;
        end

        // A new event in the clearing cycle keeps the flag set.
        underrun_d = underrun_q;
        if (tick && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (bus.clear_flags) begin
            underrun_d = 1'b0;
        end

        overflow_d = overflow_q;
        if (ovf_attempt) begin
            overflow_d = 1'b1;
        end else if (bus.clear_flags) begin
            overflow_d = 1'b0;
        end

        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_out_d = (pwm_cnt_q < cur_sample_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            cur_sample_q <= PWM_MIDSCALE;
            pwm_cnt_q    <= '0;
            pwm_out_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            cur_sample_q <= cur_sample_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_out_q    <= pwm_out_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.underrun   = underrun_q;
    assign bus.overflow   = overflow_q;
    assign bus.pwm_out    = pwm_out_q;

endmodule

// File: tb/tb_audio_pwm_player.sv
// Directed bench for audio_pwm_player with DIV=16 and a 16-entry FIFO.
module tb_audio_pwm_player;
    localparam int CLK_HZ    = 160;
    localparam int SAMPLE_HZ = 10;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    audio_pwm_player_if #(.ADDR_W(AW)) bus ();

    audio_pwm_player #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       clr;
        logic [4:0] cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.write_sample = 1'b0;
        bus.enable       = 1'b0;
        bus.clear_flags  = 1'b0;
        bus.sample_in    = 8'h00;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.sample_in    = b;
        bus.write_sample = 1'b1;
        step();
        bus.write_sample = 1'b0;
    endtask

    initial begin
        int hi;
        logic [7:0] duty_val [3];
        int         duty_exp [3];

        for (int i = 0; i < 17; i++) begin
            vecs[i].wr   = 1'b1;
            vecs[i].din  = 8'(i);
            vecs[i].clr  = 1'b0;
            vecs[i].cnt  = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].full = (i >= 15);
            vecs[i].ovf  = (i == 16);
        end
        vecs[17] = '{wr: 1'b0, din: 8'h00, clr: 1'b1, cnt: 5'd16, full: 1'b1, ovf: 1'b0};
        vecs[18] = '{wr: 1'b1, din: 8'h99, clr: 1'b1, cnt: 5'd16, full: 1'b1, ovf: 1'b1};

        duty_val[0] = 8'h00; duty_exp[0] = 0;
        duty_val[1] = 8'h40; duty_exp[1] = 64;
        duty_val[2] = 8'hFF; duty_exp[2] = 255;

        // Reset state and idle PWM at midscale
        do_reset();
        check("rst_empty", 32'(bus.fifo_empty), 1);
        check("rst_full", 32'(bus.fifo_full), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_underrun", 32'(bus.underrun), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_pwm", 32'(bus.pwm_out), 0);
        check("rst_cur", 32'(dut.cur_sample_q), 32'h80);
        for (int w = 0; w < 3; w++) begin
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                step();
                hi += int'(bus.pwm_out);
            end
            check($sformatf("idle_duty_w%0d", w), 32'(hi), 128);
        end
        steps(232);
        check("idle_empty", 32'(bus.fifo_empty), 1);
        check("idle_count", 32'(bus.fifo_count), 0);
        check("idle_underrun", 32'(bus.underrun), 0);
        check("idle_overflow", 32'(bus.overflow), 0);

        // Fill to full, overflow, clear, push+clear in the same cycle
        do_reset();
        for (int i = 0; i < 19; i++) begin
            bus.write_sample = vecs[i].wr;
            bus.sample_in    = vecs[i].din;
            bus.clear_flags  = vecs[i].clr;
            step();
            bus.write_sample = 1'b0;
            bus.clear_flags  = 1'b0;
            check($sformatf("fill%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].cnt));
            check($sformatf("fill%0d_full", i), 32'(bus.fifo_full), 32'(vecs[i].full));
            check($sformatf("fill%0d_empty", i), 32'(bus.fifo_empty), 0);
            check($sformatf("fill%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
        end

        // Ordered playback, underrun at 4th tick, clear and clear-vs-set
        do_reset();
        push(8'h00);
        push(8'h40);
        push(8'hFF);
        bus.enable = 1'b1;
        steps(15);
        check("play_pre_tick_cur", 32'(dut.cur_sample_q), 32'h80);
        step();
        check("play_tick1_cur", 32'(dut.cur_sample_q), 32'h00);
        steps(16);
        check("play_tick2_cur", 32'(dut.cur_sample_q), 32'h40);
        steps(16);
        check("play_tick3_cur", 32'(dut.cur_sample_q), 32'hFF);
        check("play_tick3_empty", 32'(bus.fifo_empty), 1);
        steps(15);
        check("play_pre_tick4_underrun", 32'(bus.underrun), 0);
        step();
        check("play_tick4_underrun", 32'(bus.underrun), 1);
        check("play_tick4_cur", 32'(dut.cur_sample_q), 32'h80);
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        check("clear_underrun", 32'(bus.underrun), 0);
        steps(14);
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        check("clear_vs_set_underrun", 32'(bus.underrun), 1);
        bus.enable = 1'b0;

        // PWM duty with a sample held for 16 ticks
        for (int d = 0; d < 3; d++) begin
            do_reset();
            for (int k = 0; k < 16; k++) push(duty_val[d]);
            bus.enable = 1'b1;
            steps(16);
            check($sformatf("duty%0d_cur", d), 32'(dut.cur_sample_q), 32'(duty_val[d]));
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                step();
                hi += int'(bus.pwm_out);
            end
            check($sformatf("duty%0d_high", d), 32'(hi), 32'(duty_exp[d]));
            check($sformatf("duty%0d_underrun", d), 32'(bus.underrun), 1);
            bus.enable = 1'b0;
        end

        // Push on the tick while full
        do_reset();
        for (int k = 0; k < 16; k++) push(8'(8'h20 + k));
        bus.enable = 1'b1;
        steps(15);
        push(8'hAA);
        check("simfull_count", 32'(bus.fifo_count), 16);
        check("simfull_full", 32'(bus.fifo_full), 1);
        check("simfull_overflow", 32'(bus.overflow), 0);
        check("simfull_cur", 32'(dut.cur_sample_q), 32'h20);

        // Push on the tick while empty: no bypass
        do_reset();
        bus.enable = 1'b1;
        steps(15);
        check("simempty_pre_underrun", 32'(bus.underrun), 0);
        push(8'h33);
        check("simempty_underrun", 32'(bus.underrun), 1);
        check("simempty_count", 32'(bus.fifo_count), 1);
        check("simempty_cur", 32'(dut.cur_sample_q), 32'h80);
        steps(16);
        check("simempty_next_cur", 32'(dut.cur_sample_q), 32'h33);
        check("simempty_next_count", 32'(bus.fifo_count), 0);

        // Reset mid-playback
        do_reset();
        for (int k = 0; k < 6; k++) push(8'(8'h11 + k));
        bus.enable = 1'b1;
        steps(20);
        check("mid_pre_count", 32'(bus.fifo_count), 5);
        check("mid_pre_cur", 32'(dut.cur_sample_q), 32'h11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_count", 32'(bus.fifo_count), 0);
        check("mid_empty", 32'(bus.fifo_empty), 1);
        check("mid_underrun", 32'(bus.underrun), 0);
        check("mid_overflow", 32'(bus.overflow), 0);
        check("mid_cur", 32'(dut.cur_sample_q), 32'h80);
        check("mid_divcnt", 32'(dut.div_cnt_q), 0);
        steps(15);
        check("mid_restart_no_tick", 32'(bus.underrun), 0);
        step();
        check("mid_restart_tick", 32'(bus.underrun), 1);
        bus.enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_pwm_player.md
Name: audio_pwm_player

Overview:
- Downstream consumer of the PicoBlaze output bus. Firmware writes 8-bit unsigned audio samples to an output port; the controller gates the write strobe into this block.
- Samples are buffered in a small FIFO and popped at a fixed sample rate.
- Each popped sample drives a free-running 8-bit PWM that feeds the board audio filter.
- FIFO status returns to PicoBlaze input ports so firmware can pace its writes.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SAMPLE_HZ, 8000, playback sample rate. DIV = CLK_HZ/SAMPLE_HZ (integer, ≥ 2). Default DIV is 12500.
- FIFO_DEPTH, 16, sample FIFO entries. Must be a power of 2, ≥ 2.
- ADDR_W, 4, equal to log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  8  unsigned sample, tied to pb_out_port.
- write_sample  input  1  one-cycle push strobe (pb_write_strobe & port_id==8'h06).
- enable  input  1  playback enable (level).
- clear_flags  input  1  one-cycle pulse; clears the underrun and overflow flags.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_count  output  ADDR_W+1  current occupancy.
- underrun  output  1  sticky; a sample tick found the FIFO empty.
- overflow  output  1  sticky; a push was attempted while full.
- pwm_out  output  1  registered PWM audio output.

Behaviour:
- Reset (synchronous, active-high): all pointers and counters go to 0.
  - fifo_empty=1, fifo_full=0, fifo_count=0.
  - underrun=0, overflow=0, pwm_out=0.
  - cur_sample=8'h80 (midscale).
- Push: on a cycle with write_sample=1 and not full, write sample_in at wr_ptr, then wr_ptr+1 (wraps mod FIFO_DEPTH).
  - Push while full: data discarded, overflow<=1, pointers unchanged.
- Tick divider: div_cnt counts 0..DIV-1 while enable=1. tick=1 on the cycle div_cnt==DIV-1, then div_cnt wraps to 0.
  - While enable=0: div_cnt held at 0, no ticks, cur_sample<=8'h80.
  - The first tick after enable rises occurs DIV cycles later.
- Pop on tick:
  - If not empty: cur_sample<=mem[rd_ptr], then rd_ptr+1.
  - If empty: underrun<=1 and cur_sample<=8'h80.
- Simultaneous push and pop:
  - Not full and not empty: both occur and fifo_count is unchanged.
  - Full: the pop frees a slot, so the push is accepted; count stays FIFO_DEPTH and there is no overflow.
  - Empty: the pop sees empty, so underrun is set; the push is accepted and count becomes 1. There is no bypass.
- Status outputs: fifo_count, fifo_full and fifo_empty are registered and reflect state after the current edge. Occupancy is tracked with an explicit count register.
- clear_flags: clears both sticky flags. If the same cycle raises a new underrun or overflow event, the set wins.
- PWM:
  - pwm_cnt is an 8-bit free-running counter (0..255, wraps), running independently of enable.
  - pwm_out<=(pwm_cnt < cur_sample), registered one cycle. Period is 256 clk (390.625 kHz at 100 MHz).
  - cur_sample=0 gives a constant 0; 255 gives high 255 of every 256 cycles.
  - A new cur_sample takes effect at the next compare with no wait for period boundary.
- Reset mid-playback: FIFO contents are logically discarded via pointers, with an immediate return to the reset state. Memory contents need not be cleared.
- Latency: the push-to-status update is 1 cycle. A sample reaches pwm_out on the 2nd edge after the tick.

Decomposition:
- A shared audio package holds:
  - Port-map constants: SAMPLE_PORT=8'h06, AUDIO_STATUS_PORT=8'h07.
  - Status bit positions, bits 0..3: empty, full, underrun, overflow.
  - PWM_MIDSCALE=8'h80.
- One sub-module, sample_fifo: synchronous FIFO (push, pop, data, full, empty, count, overflow-attempt flag), parameterized by FIFO_DEPTH.
- The divider, the flags and the PWM stay in the top of the block.

Test Plan:
- Reset then idle: with enable=0, run 1000 cycles.
  - fifo_empty=1, fifo_count=0, both flags 0.
  - pwm_out high exactly 128 of every 256 cycles.
- Fill and overflow: run with CLK_HZ=160, SAMPLE_HZ=10 (DIV=16) and enable=0.
  - Push 17 samples 0x00..0x10.
  - fifo_full=1 after the 16th; count=16; overflow=1 after the 17th.
- Ordered playback: push 0x00,0x40,0xFF, then enable=1.
  - Ticks land at cycles 16, 32, 48 after enable.
  - cur_sample goes to 0x00, 0x40, 0xFF in order; PWM duty is 0/256, 64/256, 255/256.
- Underrun: at the 4th tick, with the FIFO empty, underrun=1 and cur_sample=0x80.
  - A clear_flags pulse clears underrun.
  - With clear_flags and a new underrun in the same cycle, underrun stays 1.
- Simultaneous events:
  - Push on the tick cycle with count=16: count stays 16, overflow=0.
  - Push on the tick with count=0: underrun=1, count=1.
- Reset mid-operation: with count=5 and enable=1, assert reset for 1 cycle.
  - Next cycle: count=0, empty=1, flags 0, cur_sample=0x80, div_cnt restarts from 0.
